// File: rtl/video_io_regs.sv
// video_io_regs: ISA I/O register bank for the CGA/Tandy video adapter.
// Decodes the 16-port window and holds the mode/colour registers, the indexed
// Tandy registers (border, mode select) and a vsync-committed palette. It also
// generates the blink square wave and optional ISA wait states.
module video_io_regs #(
  parameter logic [15:0] IO_BASE_ADDR    = 16'h3D0,
  parameter int          PAL_ENTRIES     = 16,
  parameter int          PAL_WIDTH       = 4,
  parameter bit          SYNC_PAL_UPDATE = 1'b1,
  parameter bit          USE_BUS_WAIT    = 1'b0,
  parameter int          WAIT_CYCLES     = 4,
  parameter logic [23:0] BLINK_MAX       = 24'd0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [14:0]                      bus_a,
  input  logic                             bus_ior_l,
  input  logic                             bus_iow_l,
  input  logic                             bus_aen,
  input  logic [7:0]                       bus_d,
  output logic [7:0]                       bus_out,
  output logic                             bus_dir,
  output logic                             bus_rdy,
  input  logic                             vsync_l,
  input  logic                             display_enable,
  input  logic                             blink_hold,
  output logic [7:0]                       control_reg,
  output logic [7:0]                       color_reg,
  output logic [3:0]                       border_col,
  output logic [4:0]                       mode_sel,
  output logic [PAL_ENTRIES*PAL_WIDTH-1:0] pal_active,
  output logic                             pal_commit,
  output logic                             blink
);

  localparam int IDXW = (PAL_ENTRIES > 1) ? $clog2(PAL_ENTRIES) : 1;

  // Address decode on the raw bus (combinational)
  logic       addr_hit;
  logic [3:0] port_off;
  logic       port_ctl, port_col, port_idx, port_data;

  assign addr_hit  = ~bus_aen && (bus_a[14:4] == IO_BASE_ADDR[14:4]);
  assign port_off  = bus_a[3:0];
  assign port_ctl  = addr_hit && (port_off == 4'h8);
  assign port_col  = addr_hit && (port_off == 4'h9);
  assign port_idx  = addr_hit && (port_off == 4'hA);
  assign port_data = addr_hit && (port_off == 4'hE);

  // Synchronisers: bit0/bit1 are the 2-FF chain, bit2 is the delayed copy
  // used for falling-edge detection.
  logic [2:0] iow_sync_reg;
  logic [2:0] vs_sync_reg;
  logic [1:0] de_sync_reg;
  logic [1:0] settle_reg;
  logic       settled;
  logic       vsync_s, de_s;
  logic       iow_fall, vs_fall;

  // Shift the asynchronous strobes and CRTC signals into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iow_sync_reg <= 3'b111;
      vs_sync_reg  <= 3'b111;
      de_sync_reg  <= 2'b00;
      settle_reg   <= 2'd0;
    end else begin
      iow_sync_reg <= {iow_sync_reg[1:0], bus_iow_l};
      vs_sync_reg  <= {vs_sync_reg[1:0], vsync_l};
      de_sync_reg  <= {de_sync_reg[0], display_enable};
      // Edge detection is only trusted once every stage holds a real sample,
      // so a strobe already low at reset release is not seen as an edge.
      settle_reg   <= (settle_reg == 2'd3) ? 2'd3 : settle_reg + 2'd1;
    end
  end

  assign settled  = (settle_reg == 2'd3);
  assign vsync_s  = vs_sync_reg[1];
  assign de_s     = de_sync_reg[1];
  assign iow_fall = settled & iow_sync_reg[2] & ~iow_sync_reg[1];
  assign vs_fall  = settled & vs_sync_reg[2] & ~vs_sync_reg[1];

  // Read path: only the status port drives the bus
  assign bus_dir = port_idx & ~bus_ior_l;
  assign bus_out = bus_dir ? {4'hF, vsync_s, 2'b10, ~de_s} : 8'h00;

  // Write decode during the single-cycle strobe
  logic [4:0]      idx_reg;
  logic [3:0]      idx_inc;
  logic            pal_wr;
  logic [IDXW-1:0] pal_sel;
  logic            commit_stb;

  assign pal_wr     = iow_fall & port_data & idx_reg[4];
  assign pal_sel    = idx_reg[IDXW-1:0];
  assign idx_inc    = (idx_reg[3:0] == 4'(PAL_ENTRIES - 1)) ? 4'h0 : idx_reg[3:0] + 4'h1;
  assign commit_stb = SYNC_PAL_UPDATE & vs_fall;

  // Mode/colour/index/Tandy register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_reg <= 8'h29;
      color_reg   <= 8'h00;
      idx_reg     <= 5'h00;
      border_col  <= 4'h0;
      mode_sel    <= 5'h00;
    end else if (iow_fall) begin
      if (port_ctl) control_reg <= bus_d;
      if (port_col) color_reg   <= bus_d;
      if (port_idx) idx_reg     <= bus_d[4:0];
      if (port_data) begin
        if (idx_reg[4])            idx_reg    <= {idx_reg[4], idx_inc};
        else if (idx_reg == 5'h02) border_col <= bus_d[3:0];
        else if (idx_reg == 5'h03) mode_sel   <= bus_d[4:0];
      end
    end
  end

  // Palette: one shadow/active register pair per entry
  logic [PAL_WIDTH-1:0] shadow_reg [PAL_ENTRIES];
  logic [PAL_WIDTH-1:0] active_reg [PAL_ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < PAL_ENTRIES; gi++) begin : g_pal
      logic entry_hit;
      assign entry_hit = pal_wr && (pal_sel == IDXW'(gi));

      // Shadow takes every write; active follows on commit (or directly)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= PAL_WIDTH'(gi);
          active_reg[gi] <= PAL_WIDTH'(gi);
        end else begin
          if (entry_hit) shadow_reg[gi] <= bus_d[PAL_WIDTH-1:0];
          if (!SYNC_PAL_UPDATE) begin
            if (entry_hit) active_reg[gi] <= bus_d[PAL_WIDTH-1:0];
          end else if (commit_stb) begin
            // A write landing on the commit cycle must not be lost
            active_reg[gi] <= entry_hit ? bus_d[PAL_WIDTH-1:0] : shadow_reg[gi];
          end
        end
      end

      assign pal_active[gi*PAL_WIDTH +: PAL_WIDTH] = active_reg[gi];
    end
  endgenerate

  // Commit pulse, registered alongside the active copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pal_commit <= 1'b0;
    else        pal_commit <= commit_stb;
  end

  // Blink: half-period counter, frozen by blink_hold
  logic [23:0] blink_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= 24'd0;
      blink         <= 1'b0;
    end else if (!blink_hold) begin
      if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg <= 24'd0;
        blink         <= ~blink;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 24'd1;
      end
    end
  end

  generate
    if (USE_BUS_WAIT) begin : g_wait
      logic [2:0] ior_sync_reg;
      logic [3:0] wait_cnt_reg;
      logic       rdy_reg;
      logic       ior_fall;
      logic       port_any;
      logic       wait_start;

      assign port_any   = port_ctl | port_col | port_idx | port_data;
      assign ior_fall   = settled & ior_sync_reg[2] & ~ior_sync_reg[1];
      assign wait_start = (ior_fall | iow_fall) & port_any;

      // Hold bus_rdy low for WAIT_CYCLES after each decoded access edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ior_sync_reg <= 3'b111;
          wait_cnt_reg <= 4'd0;
          rdy_reg      <= 1'b1;
        end else begin
          ior_sync_reg <= {ior_sync_reg[1:0], bus_ior_l};
          if (wait_start) begin
            wait_cnt_reg <= 4'(WAIT_CYCLES);
            rdy_reg      <= 1'b0;
          end else if (wait_cnt_reg != 4'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
            rdy_reg      <= (wait_cnt_reg == 4'd1);
          end
        end
      end

      assign bus_rdy = rdy_reg;
    end else begin : g_no_wait
      assign bus_rdy = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_video_io_regs.sv
// tb_video_io_regs: self-checking bench for video_io_regs (vsync-committed
// palette, wait states enabled, BLINK_MAX=3).
module tb_video_io_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] bus_a = 15'h0;
  logic        bus_ior_l = 1'b1;
  logic        bus_iow_l = 1'b1;
  logic        bus_aen = 1'b0;
  logic [7:0]  bus_d = 8'h0;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;
  logic        vsync_l = 1'b1;
  logic        display_enable = 1'b0;
  logic        blink_hold = 1'b0;
  logic [7:0]  control_reg, color_reg;
  logic [3:0]  border_col;
  logic [4:0]  mode_sel;
  logic [63:0] pal_active;
  logic        pal_commit;
  logic        blink;

  video_io_regs #(
    .IO_BASE_ADDR(16'h3D0), .PAL_ENTRIES(16), .PAL_WIDTH(4),
    .SYNC_PAL_UPDATE(1'b1), .USE_BUS_WAIT(1'b1), .WAIT_CYCLES(4),
    .BLINK_MAX(24'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_ior_l(bus_ior_l),
    .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_d(bus_d),
    .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
    .vsync_l(vsync_l), .display_enable(display_enable), .blink_hold(blink_hold),
    .control_reg(control_reg), .color_reg(color_reg), .border_col(border_col),
    .mode_sel(mode_sel), .pal_active(pal_active), .pal_commit(pal_commit),
    .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: sel 0..15 palette entry, 16 border, 17 mode, 18 control,
  // 19 index register, 20 colour
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [14:0] a;
    logic [7:0]  d;
    logic [3:0]  border;
    logic [4:0]  mode;
    logic [4:0]  idx;
    logic [7:0]  color;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int sel);
    logic [31:0] v;
    v = 32'h0;
    if (sel < 16) v = 32'(pal_active[sel*4 +: 4]);
    else begin
      case (sel)
        16: v = 32'(border_col);
        17: v = 32'(mode_sel);
        18: v = 32'(control_reg);
        19: v = 32'(dut.idx_reg);
        default: v = 32'(color_reg);
      endcase
    end
    return v;
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, actual(e.sel), e.exp);
    end
  endtask

  task automatic io_write(input logic [14:0] a, input logic [7:0] d, input int len, input logic aen);
    @(negedge clk);
    bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
    repeat (len) @(negedge clk);
    bus_iow_l = 1'b1; bus_aen = 1'b0;
    repeat (4) @(negedge clk);
    $display("io_write %h <= %h (len %0d, aen %0b)", a, d, len, aen);
  endtask

  // Wait up to 10 edges for pal_commit; returns edge count, 0 on timeout
  task automatic wait_commit(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (pal_commit) begin lat = k; break; end
    end
  endtask

  // Edges until blink changes, 0 if it does not within the bound
  task automatic edges_to_toggle(output int n);
    logic b0;
    b0 = blink;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (blink != b0) begin n = k; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat, lowcnt, firstlow, n;
    logic bsave;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_control", 32'(control_reg), 32'h29);
    check("rst_color", 32'(color_reg), 32'h00);
    check("rst_pal5", 32'(pal_active[5*4 +: 4]), 32'h5);
    check("rst_pal15", 32'(pal_active[15*4 +: 4]), 32'hF);
    check("rst_rdy", 32'(bus_rdy), 32'h1);
    check("rst_blink", 32'(blink), 32'h0);
    check("rst_commit", 32'(pal_commit), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ---------------- control write, 20-cycle iow pulse ----------------
    bus_a = 15'h3D8; bus_d = 8'h0A; bus_aen = 1'b0; bus_iow_l = 1'b0;
    @(posedge clk);          // N
    @(posedge clk); #1;      // N+1
    check("ctl_before", 32'(control_reg), 32'h29);
    @(posedge clk); #1;      // N+2
    check("ctl_after", 32'(control_reg), 32'h0A);
    repeat (17) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (4) @(negedge clk);
    $display("io_write 3d8 <= 0a (len 20)");
    check("ctl_held", 32'(control_reg), 32'h0A);

    // write with AEN high must be ignored
    io_write(15'h3D8, 8'h77, 4, 1'b1);
    check("ctl_aen", 32'(control_reg), 32'h0A);

    // ---------------- palette auto-increment ----------------
    io_write(15'h3DA, 8'h1E, 4, 1'b0);
    push("pal14", 14, 32'h7);
    io_write(15'h3DE, 8'h07, 20, 1'b0);   // long strobe: one increment only
    push("pal15", 15, 32'h8);
    io_write(15'h3DE, 8'h08, 4, 1'b0);
    push("pal0", 0, 32'h9);
    io_write(15'h3DE, 8'h09, 4, 1'b0);
    push("pal13_kept", 13, 32'hD);
    check("idx_autoinc", 32'(dut.idx_reg), 32'h11);
    check("pal14_precommit", 32'(pal_active[14*4 +: 4]), 32'hE);
    check("pal15_precommit", 32'(pal_active[15*4 +: 4]), 32'hF);
    check("pal0_precommit", 32'(pal_active[0 +: 4]), 32'h0);

    @(negedge clk); vsync_l = 1'b0;
    wait_commit(lat);
    check("commit_latency", 32'(lat), 32'd3);
    drain();
    @(posedge clk); #1;
    check("commit_pulse_len", 32'(pal_commit), 32'h0);
    @(negedge clk); vsync_l = 1'b1;
    repeat (5) @(negedge clk);

    // ---------------- palette write coincident with commit ----------------
    push("pal1_coincident", 1, 32'hB);
    bus_a = 15'h3DE; bus_d = 8'h0B; bus_aen = 1'b0; bus_iow_l = 1'b0; vsync_l = 1'b0;
    wait_commit(lat);
    check("coincident_latency", 32'(lat), 32'd3);
    drain();
    repeat (2) @(negedge clk);
    bus_iow_l = 1'b1; vsync_l = 1'b1;
    repeat (5) @(negedge clk);
    $display("io_write 3de <= 0b with vsync commit");
    check("pal1_after", 32'(pal_active[1*4 +: 4]), 32'hB);

    // ---------------- indexed registers (table) ----------------
    vecs[0] = '{a: 15'h3DA, d: 8'h02, border: 4'h0, mode: 5'h00, idx: 5'h02, color: 8'h00};
    vecs[1] = '{a: 15'h3DE, d: 8'hFC, border: 4'hC, mode: 5'h00, idx: 5'h02, color: 8'h00};
    vecs[2] = '{a: 15'h3DA, d: 8'h03, border: 4'hC, mode: 5'h00, idx: 5'h03, color: 8'h00};
    vecs[3] = '{a: 15'h3DE, d: 8'h1F, border: 4'hC, mode: 5'h1F, idx: 5'h03, color: 8'h00};
    vecs[4] = '{a: 15'h3DA, d: 8'h07, border: 4'hC, mode: 5'h1F, idx: 5'h07, color: 8'h00};
    vecs[5] = '{a: 15'h3DE, d: 8'h55, border: 4'hC, mode: 5'h1F, idx: 5'h07, color: 8'h00};
    vecs[6] = '{a: 15'h3D9, d: 8'h3C, border: 4'hC, mode: 5'h1F, idx: 5'h07, color: 8'h3C};
    for (int i = 0; i < 7; i++) begin
      push($sformatf("vec%0d_border", i), 16, 32'(vecs[i].border));
      push($sformatf("vec%0d_mode", i), 17, 32'(vecs[i].mode));
      push($sformatf("vec%0d_idx", i), 19, 32'(vecs[i].idx));
      push($sformatf("vec%0d_color", i), 20, 32'(vecs[i].color));
      io_write(vecs[i].a, vecs[i].d, 4, 1'b0);
      drain();
    end

    // ---------------- status read and wait states ----------------
    @(negedge clk); vsync_l = 1'b0; display_enable = 1'b1;
    repeat (4) @(negedge clk);
    bus_a = 15'h3DA; bus_aen = 1'b0; bus_ior_l = 1'b0;
    #1;
    $display("io_read 3da -> %h dir %0b", bus_out, bus_dir);
    check("status_f4", 32'(bus_out), 32'hF4);
    check("status_dir", 32'(bus_dir), 32'h1);
    lowcnt = 0; firstlow = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (!bus_rdy) begin
        lowcnt++;
        if (firstlow == 0) firstlow = k;
      end
    end
    check("rdy_low_cycles", 32'(lowcnt), 32'd4);
    check("rdy_fall_edge", 32'(firstlow), 32'd3);
    @(negedge clk); bus_ior_l = 1'b1;
    repeat (4) @(negedge clk);

    bus_a = 15'h3D9; bus_ior_l = 1'b0;
    #1;
    $display("io_read 3d9 -> %h dir %0b", bus_out, bus_dir);
    check("read3d9_dir", 32'(bus_dir), 32'h0);
    check("read3d9_out", 32'(bus_out), 32'h00);
    @(negedge clk); bus_ior_l = 1'b1;

    vsync_l = 1'b1; display_enable = 1'b0;
    repeat (4) @(negedge clk);
    bus_a = 15'h3DA; bus_ior_l = 1'b0;
    #1;
    $display("io_read 3da -> %h dir %0b", bus_out, bus_dir);
    check("status_fd", 32'(bus_out), 32'hFD);
    @(negedge clk); vsync_l = 1'b0;
    @(posedge clk); #1;
    check("status_lag1", 32'(bus_out), 32'hFD);
    @(posedge clk); #1;
    check("status_lag2", 32'(bus_out), 32'hF5);
    @(negedge clk); bus_ior_l = 1'b1; vsync_l = 1'b1;
    repeat (5) @(negedge clk);

    // ---------------- blink ----------------
    edges_to_toggle(n);
    check("blink_sync", 32'(n != 0), 32'h1);
    edges_to_toggle(n);
    check("blink_period", 32'(n), 32'd4);
    $display("blink half-period %0d", n);
    @(negedge clk); blink_hold = 1'b1;
    bsave = blink;
    repeat (10) @(posedge clk);
    #1;
    check("blink_hold", 32'(blink), 32'(bsave));
    @(negedge clk); blink_hold = 1'b0;
    #1;
    edges_to_toggle(n);
    check("blink_after_hold", 32'(n), 32'd4);

    // ---------------- reset mid-access ----------------
    @(negedge clk);
    bus_a = 15'h3D8; bus_d = 8'h55; bus_aen = 1'b0; bus_iow_l = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_control", 32'(control_reg), 32'h29);
    check("midrst_border", 32'(border_col), 32'h0);
    check("midrst_pal1", 32'(pal_active[1*4 +: 4]), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("io_write 3d8 <= 55 across reset release");
    check("no_write_after_rst", 32'(control_reg), 32'h29);
    @(negedge clk); bus_iow_l = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
